// File: rtl/timer_bridge_pkg.sv
// Shared definitions for timer_bridge: register offsets, channel FSM encoding, defaults.
`timescale 1ns/1ps
package timer_bridge_pkg;
  localparam logic [31:0] DEF_BASE    = 32'h0000_7F00;
  localparam int          MAX_CH      = 6;

  localparam logic [3:0]  OFF_CTRL    = 4'h0;
  localparam logic [3:0]  OFF_PRESET  = 4'h4;
  localparam logic [3:0]  OFF_COUNT   = 4'h8;
  localparam logic [7:0]  OFF_PENDING = 8'h60;
  localparam logic [7:0]  OFF_MASK    = 8'h64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } ch_state_e;
endpackage

// File: rtl/timer_bridge_ch.sv
// timer_ch: one down-counting timer channel (CTRL/PRESET/COUNT + FSM).
// MODE bit is only writable when TIMER_BRIDGE_AUTORELOAD_EN is defined.
`timescale 1ns/1ps
module timer_ch
  import timer_bridge_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_ctrl_i,
  input  logic        we_preset_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  rsel_i,
  output logic [31:0] rdata_o,
  output logic        expire_o
);
  ch_state_e   state_q, state_d;
  logic        en_q, en_d;
  logic        mode_q, mode_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      mode_q   <= 1'b0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      preset_q <= preset_d;
      count_q  <= count_d;
    end
  end

  // Software CTRL writes are applied last so they win over the hardware EN clear in INT.
  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    mode_d   = mode_q;
    preset_d = preset_q;
    count_d  = count_q;
    case (state_q)
      ST_IDLE: begin
        if (en_q) state_d = ST_LOAD;
        else      state_d = ST_IDLE;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en_q) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = 32'd0;
          state_d = ST_INT;
        end
      end
      ST_INT: begin
        if (mode_q) begin
          state_d = ST_LOAD;
        end else begin
          en_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (we_ctrl_i) begin
      en_d = wdata_i[0];
`ifdef TIMER_BRIDGE_AUTORELOAD_EN
      mode_d = wdata_i[1];
`else
      mode_d = 1'b0;
`endif
    end
    if (we_preset_i) preset_d = wdata_i;
  end

  always_comb begin
    case (rsel_i)
      OFF_CTRL[3:2]:   rdata_o = {30'd0, mode_q, en_q};
      OFF_PRESET[3:2]: rdata_o = preset_q;
      OFF_COUNT[3:2]:  rdata_o = count_q;
      default:         rdata_o = 32'd0;
    endcase
  end

  assign expire_o = (state_q == ST_INT);
endmodule

// File: rtl/timer_bridge.sv
// timer_bridge: decodes the 0x7Fxx device window into N_CH timers plus PENDING/MASK and drives HWInt.
// Define TIMER_BRIDGE_AUTORELOAD_EN to enable the per-channel auto-reload MODE bit.
`timescale 1ns/1ps
module timer_bridge
  import timer_bridge_pkg::*;
#(
  parameter int          N_CH = 2,
  parameter logic [31:0] BASE = DEF_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic [7:2]  HWInt
);
  logic [31:0]     off_s;
  logic            win_s;
  logic [3:0]      slot_s;
  logic            pend_sel_s;
  logic            mask_sel_s;
  logic [N_CH-1:0] expire_s;
  logic [N_CH-1:0] pending_q, pending_d;
  logic [N_CH-1:0] mask_q, mask_d;
  logic [31:0]     ch_rdata_s [N_CH];
  logic [1:0]      unused_addr_s;

  assign off_s         = Addr - BASE;
  assign win_s         = (off_s[31:8] == 24'd0);
  assign slot_s        = off_s[7:4];
  assign pend_sel_s    = win_s && (off_s[7:2] == OFF_PENDING[7:2]);
  assign mask_sel_s    = win_s && (off_s[7:2] == OFF_MASK[7:2]);
  assign unused_addr_s = off_s[1:0];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic sel_s;
    assign sel_s = win_s && (slot_s == 4'(i));
    timer_ch u_ch (
      .clk_i       (clk),
      .rst_i       (reset),
      .we_ctrl_i   (WE && sel_s && (off_s[3:2] == OFF_CTRL[3:2])),
      .we_preset_i (WE && sel_s && (off_s[3:2] == OFF_PRESET[3:2])),
      .wdata_i     (Din),
      .rsel_i      (off_s[3:2]),
      .rdata_o     (ch_rdata_s[i]),
      .expire_o    (expire_s[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  end

  // An expiry sets its pending bit even when a write-1-clear lands on the same edge.
  always_comb begin
    pending_d = pending_q;
    mask_d    = mask_q;
    if (WE && mask_sel_s) mask_d = Din[N_CH-1:0];
    for (int i = 0; i < N_CH; i++) begin
      if (expire_s[i])                        pending_d[i] = 1'b1;
      else if (WE && pend_sel_s && Din[i])    pending_d[i] = 1'b0;
      else                                    pending_d[i] = pending_q[i];
    end
  end

  always_comb begin
    Dout = 32'd0;
    if (pend_sel_s) begin
      Dout = 32'(pending_q);
    end else if (mask_sel_s) begin
      Dout = 32'(mask_q);
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (win_s && (slot_s == 4'(i))) Dout = ch_rdata_s[i];
      end
    end
  end

  always_comb begin
    HWInt = 6'd0;
    HWInt[N_CH+1:2] = pending_q & mask_q;
  end
endmodule
